mux_scan_sequencer: RTL and testbench

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_scan_sequencer.sv | 143 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps a 4-bit select through all 16 channels of an external
//               16:1 mux, holds each channel for SETTLE cycles, and samples
//               the mux output on the last cycle of each hold. The 16 samples
//               are assembled into a word that is published on completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE     : cycles each select value is held (1..15)
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : synchronous active-high reset
//   start      : scan request, honoured only in IDLE
//   abort      : cancel scan in progress, returns to IDLE
//   continuous : restart automatically after each completed scan
//   mux_in     : single-bit output of the downstream 16:1 mux
//   select     : registered channel index driven to the mux
//   busy       : high while scanning
//   done       : single-cycle completion pulse
//   scan_word  : last completed scan, bit i sampled while select was i
// ============================================================================
module mux_scan_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        continuous,
  input  logic        mux_in,
  output logic [3:0]  select,
  output logic        busy,
  output logic        done,
  output logic [15:0] scan_word
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value of cnt on the sampling cycle of each channel hold.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] SEL_LAST = 4'd15;

  state_t      state, state_next;
  logic [3:0]  select_next;
  logic [3:0]  cnt, cnt_next;
  logic [15:0] work, work_next;
  logic [15:0] scan_word_next;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      select    <= 4'd0;
      cnt       <= 4'd0;
      work      <= 16'd0;
      scan_word <= 16'd0;
    end else begin
      state     <= state_next;
      select    <= select_next;
      cnt       <= cnt_next;
      work      <= work_next;
      scan_word <= scan_word_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    select_next    = select;
    cnt_next       = cnt;
    work_next      = work;
    scan_word_next = scan_word;

    if (abort) begin
      // Partial work is thrown away; the published word is left untouched.
      state_next  = IDLE;
      select_next = 4'd0;
      cnt_next    = 4'd0;
      work_next   = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          select_next = 4'd0;
          cnt_next    = 4'd0;
          if (start) begin
            state_next = SCAN;
            work_next  = 16'd0;
          end
        end

        SCAN: begin
          if (cnt == CNT_LAST) begin
            cnt_next          = 4'd0;
            work_next[select] = mux_in;
            if (select == SEL_LAST) begin
              // Publish including the bit captured on this very edge.
              state_next     = DONE;
              scan_word_next = work_next;
            end else begin
              select_next = select + 4'd1;
            end
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end

        DONE: begin
          select_next = 4'd0;
          cnt_next    = 4'd0;
          if (continuous) begin
            state_next = SCAN;
            work_next  = 16'd0;
          end else begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next  = IDLE;
          select_next = 4'd0;
          cnt_next    = 4'd0;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register, so an abort in
  // DONE cannot retract the pulse already being presented.
  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_sequencer
// Description : Self-checking bench for mux_scan_sequencer. Instance a uses
//               SETTLE=2, instance b uses SETTLE=1. Each instance sees a
//               bench mux model driven from its own data word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_start, a_abort, a_cont;
  logic [15:0] a_data;
  logic        a_mux_in;
  logic [3:0]  a_select;
  logic        a_busy, a_done;
  logic [15:0] a_word;

  logic        b_start, b_abort, b_cont;
  logic [15:0] b_data;
  logic        b_mux_in;
  logic [3:0]  b_select;
  logic        b_busy, b_done;
  logic [15:0] b_word;

  assign a_mux_in = a_data[a_select];
  assign b_mux_in = b_data[b_select];

  mux_scan_sequencer #(.SETTLE(2)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .continuous(a_cont), .mux_in(a_mux_in), .select(a_select),
    .busy(a_busy), .done(a_done), .scan_word(a_word)
  );

  mux_scan_sequencer #(.SETTLE(1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .continuous(b_cont), .mux_in(b_mux_in), .select(b_select),
    .busy(b_busy), .done(b_done), .scan_word(b_word)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] sel;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[12];

  // Full SETTLE=2 scan on instance a starting from IDLE; checks every cycle.
  task automatic scan_a(input logic [15:0] data, input string tag);
    a_data  = data;
    a_start = 1'b1;
    @(posedge clk);                       // edge T samples start
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);                     // value sampled at edge T+c
      a_start = 1'b0;
      if (c <= 32) begin
        check({tag, "_sel"},  32'(a_select), 32'((c - 1) / 2));
        check({tag, "_busy"}, 32'(a_busy), 32'd1);
        check({tag, "_done"}, 32'(a_done), 32'd0);
      end else if (c == 33) begin
        check({tag, "_done33"}, 32'(a_done), 32'd1);
        check({tag, "_busy33"}, 32'(a_busy), 32'd0);
        check({tag, "_word"},   32'(a_word), 32'(data));
      end else begin
        check({tag, "_done_end"}, 32'(a_done), 32'd0);
        check({tag, "_busy_end"}, 32'(a_busy), 32'd0);
        check({tag, "_sel_end"},  32'(a_select), 32'd0);
      end
      if (c < 34) @(posedge clk);
    end
  endtask

  // Bounded wait for instance a to reach a given channel.
  task automatic wait_sel_a(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (a_select !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_timeout"}, 32'(a_select), 32'(target));
  endtask

  initial begin
    reset = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_cont = 1'b0; a_data = 16'h0000;
    b_start = 1'b0; b_abort = 1'b0; b_cont = 1'b0; b_data = 16'h0000;

    // ---------------- table: reset, idle, start/abort interplay -----------
    //            rst   start abort sel   busy  done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};  // reset
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};  // idle x5
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};  // abort+start: stay idle
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};  // start -> SCAN
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};  // start held: ignored
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};  // abort -> IDLE
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};  // stays idle
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};  // reset beats start

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      reset   = vecs[i].rst;
      a_start = vecs[i].start;
      a_abort = vecs[i].abort;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_sel", i),  32'(a_select), 32'(vecs[i].sel));
      check($sformatf("vec%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 32'(a_done), 32'(vecs[i].done));
      check($sformatf("vec%0d_word", i), 32'(a_word), 32'h0);
    end
    reset = 1'b0; a_start = 1'b0; a_abort = 1'b0;
    @(negedge clk);

    // ---------------- continuous mode, data change in scan 2 --------------
    a_cont = 1'b1;
    a_data = 16'h1234;
    a_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      check($sformatf("cont_done_c%0d", c), 32'(a_done),
            32'((c == 33) || (c == 66)));
      if (c == 33) check("cont_word1", 32'(a_word), 32'h1234);
      if (c == 34) begin
        check("cont_restart_busy", 32'(a_busy), 32'd1);
        check("cont_restart_sel", 32'(a_select), 32'd0);
        a_data = 16'hFEDC;                // before channel 0 is sampled
      end
      if (c == 40) a_cont = 1'b0;        // mid-scan change must not matter
      if (c == 50) check("cont_mid_word", 32'(a_word), 32'h1234);
      if (c == 66) check("cont_word2", 32'(a_word), 32'hFEDC);
      if (c >= 67) check("cont_stop_busy", 32'(a_busy), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);

    // ---------------- single scan, SETTLE=2 --------------------------------
    scan_a(16'hA5C3, "s2");

    // ---------------- abort at select 7 ------------------------------------
    a_data = 16'hFFFF;
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    wait_sel_a(4'd7, "abort");
    a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_sel",  32'(a_select), 32'd0);
    check("abort_done", 32'(a_done), 32'd0);
    check("abort_word", 32'(a_word), 32'hA5C3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(a_done), 32'd0);
    end
    check("abort_word_later", 32'(a_word), 32'hA5C3);
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b0;
    check("abort_start_idle", 32'(a_busy), 32'd0);

    // ---------------- reset at select 9, then fresh scan --------------------
    a_data = 16'h0F0F;
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    wait_sel_a(4'd9, "rst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_sel",  32'(a_select), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_word", 32'(a_word), 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("rst_stay_idle", 32'({a_busy, a_done}), 32'd0);
    end
    scan_a(16'h5A3C, "post_rst");

    // ---------------- single scan, SETTLE=1 --------------------------------
    b_data = 16'h8001;
    b_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      check($sformatf("s1_done_c%0d", c), 32'(b_done), 32'(c == 17));
      if (c <= 16) check("s1_sel", 32'(b_select), 32'(c - 1));
      if (c == 17) check("s1_word", 32'(b_word), 32'h8001);
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
